// File: rtl/text_display_pkg.sv
// Shared geometry and character constants for the text display.
// Both the console writer and the glyph/pixel reader import this so the
// character buffer layout is agreed in one place.
package text_display_pkg;

  localparam int COLS    = 80;   // characters per row (640 px / 8 px glyph)
  localparam int ROWS    = 60;   // character rows (480 px / 8 line glyph)
  localparam int ADDR_W  = 13;   // 2**ADDR_W >= COLS*ROWS
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  // Writer FSM encoding
  localparam logic [1:0] ST_CLR_ALL  = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_CLR_LINE = 2'd2;

  // True for bytes that are stored as glyphs (space through tilde)
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
  endfunction

endpackage

// File: rtl/text_addr_gen.sv
// Cursor address generator: tracks the cursor's physical row and its base
// address (phys_row*COLS, stepped by COLS instead of multiplied), plus the
// scroll ring offset. Physical row always equals (scroll_row + cursor_row)
// mod ROWS, and every row advance (with or without scroll) steps it by one.
module text_addr_gen
  import text_display_pkg::*;
#(
  parameter int COLS   = text_display_pkg::COLS,
  parameter int ROWS   = text_display_pkg::ROWS,
  parameter int ADDR_W = text_display_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_i,     // home: phys row 0, scroll 0
  input  logic                    adv_i,      // cursor moves down one physical row
  input  logic                    scroll_i,   // ring offset steps by one row
  input  logic [$clog2(COLS)-1:0] col_i,
  output logic [ADDR_W-1:0]       cur_addr_o, // col_i on the current row
  output logic [ADDR_W-1:0]       nxt_addr_o, // col_i on the following row
  output logic [$clog2(ROWS)-1:0] scroll_row_o
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0]  phys_row_q, phys_row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ROW_W-1:0]  scroll_q, scroll_d;
  logic [ROW_W-1:0]  phys_row_nxt;
  logic [ADDR_W-1:0] row_base_nxt;

  // Next-row values with wrap at the bottom of the ring, and register updates
  always_comb begin
    if (phys_row_q == LAST_ROW) begin
      phys_row_nxt = '0;
      row_base_nxt = '0;
    end else begin
      phys_row_nxt = phys_row_q + ROW_W'(1);
      row_base_nxt = row_base_q + ADDR_W'(COLS);
    end

    phys_row_d = phys_row_q;
    row_base_d = row_base_q;
    scroll_d   = scroll_q;
    if (init_i) begin
      phys_row_d = '0;
      row_base_d = '0;
      scroll_d   = '0;
    end else begin
      if (adv_i) begin
        phys_row_d = phys_row_nxt;
        row_base_d = row_base_nxt;
      end else begin
        phys_row_d = phys_row_q;
      end
      if (scroll_i) begin
        scroll_d = (scroll_q == LAST_ROW) ? '0 : scroll_q + ROW_W'(1);
      end else begin
        scroll_d = scroll_q;
      end
    end
  end

  // Row tracking registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phys_row_q <= '0;
      row_base_q <= '0;
      scroll_q   <= '0;
    end else begin
      phys_row_q <= phys_row_d;
      row_base_q <= row_base_d;
      scroll_q   <= scroll_d;
    end
  end

  assign cur_addr_o   = row_base_q + ADDR_W'(col_i);
  assign nxt_addr_o   = row_base_nxt + ADDR_W'(col_i);
  assign scroll_row_o = scroll_q;

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for the text display buffer. Accepts ASCII over
// valid/ready, keeps a cursor, interprets CR/LF/BS/FF, wraps and scrolls
// via a ring offset, and clears the whole screen out of reset.
module text_console_writer
  import text_display_pkg::*;
#(
  parameter int COLS   = text_display_pkg::COLS,
  parameter int ROWS   = text_display_pkg::ROWS,
  parameter int ADDR_W = text_display_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    char_valid,
  input  logic [7:0]              char_data,
  output logic                    char_ready,
  output logic                    buf_we,
  output logic [ADDR_W-1:0]       buf_addr,
  output logic [7:0]              buf_data,
  output logic [$clog2(ROWS)-1:0] scroll_row,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  logic [1:0]        state_q, state_d;
  logic              clr_pend_q, clr_pend_d;  // clear started but first write not yet issued
  logic [COL_W-1:0]  clr_col_q, clr_col_d;    // column of the clear write on the bus
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;

  logic              ag_init, ag_adv, ag_scroll;
  logic [COL_W-1:0]  ag_col;
  logic [ADDR_W-1:0] ag_cur_addr, ag_nxt_addr;
  logic              at_bottom;

  text_addr_gen #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_i       (ag_init),
    .adv_i        (ag_adv),
    .scroll_i     (ag_scroll),
    .col_i        (ag_col),
    .cur_addr_o   (ag_cur_addr),
    .nxt_addr_o   (ag_nxt_addr),
    .scroll_row_o (scroll_row)
  );

  assign at_bottom = (row_q == LAST_ROW);

  // FSM, control-character decode and next write on the buffer port
  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q;
    clr_col_d  = clr_col_q;
    col_d      = col_q;
    row_d      = row_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    ag_init    = 1'b0;
    ag_adv     = 1'b0;
    ag_scroll  = 1'b0;
    ag_col     = col_q;

    case (state_q)
      ST_CLR_ALL: begin
        // linear sweep of the whole buffer, addr_q doubles as the counter
        if (clr_pend_q) begin
          we_d       = 1'b1;
          addr_d     = '0;
          data_d     = ASCII_SPACE;
          clr_pend_d = 1'b0;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          col_d   = '0;
          row_d   = '0;
          ag_init = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          data_d = ASCII_SPACE;
        end
      end

      ST_CLR_LINE: begin
        // blank the new bottom row; cursor row base already points at it
        if (clr_pend_q) begin
          ag_col     = '0;
          we_d       = 1'b1;
          addr_d     = ag_cur_addr;
          data_d     = ASCII_SPACE;
          clr_pend_d = 1'b0;
          clr_col_d  = '0;
        end else if (clr_col_q == LAST_COL) begin
          state_d = ST_IDLE;
        end else begin
          ag_col    = clr_col_q + COL_W'(1);
          we_d      = 1'b1;
          addr_d    = ag_cur_addr;
          data_d    = ASCII_SPACE;
          clr_col_d = clr_col_q + COL_W'(1);
        end
      end

      ST_IDLE: begin
        if (char_valid) begin
          if (is_printable(char_data)) begin
            we_d   = 1'b1;
            addr_d = ag_cur_addr;
            data_d = char_data;
            if (col_q == LAST_COL) begin
              col_d  = '0;
              ag_adv = 1'b1;
              if (at_bottom) begin
                // the glyph write goes out first, the line clear follows
                ag_scroll  = 1'b1;
                state_d    = ST_CLR_LINE;
                clr_pend_d = 1'b1;
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            case (char_data)
              ASCII_LF: begin
                col_d  = '0;
                ag_adv = 1'b1;
                if (at_bottom) begin
                  // first clear write issued right away on the next row
                  ag_scroll  = 1'b1;
                  state_d    = ST_CLR_LINE;
                  clr_pend_d = 1'b0;
                  clr_col_d  = '0;
                  ag_col     = '0;
                  we_d       = 1'b1;
                  addr_d     = ag_nxt_addr;
                  data_d     = ASCII_SPACE;
                end else begin
                  row_d = row_q + ROW_W'(1);
                end
              end
              ASCII_CR: begin
                col_d = '0;
              end
              ASCII_BS: begin
                if (col_q != '0) begin
                  ag_col = col_q - COL_W'(1);
                  col_d  = col_q - COL_W'(1);
                  we_d   = 1'b1;
                  addr_d = ag_cur_addr;
                  data_d = ASCII_SPACE;
                end else begin
                  col_d = col_q;
                end
              end
              ASCII_FF: begin
                state_d    = ST_CLR_ALL;
                clr_pend_d = 1'b0;
                we_d       = 1'b1;
                addr_d     = '0;
                data_d     = ASCII_SPACE;
              end
              default: begin
                col_d = col_q;
              end
            endcase
          end
        end else begin
          we_d = 1'b0;
        end
      end

      default: begin
        state_d    = ST_CLR_ALL;
        clr_pend_d = 1'b1;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset restarts a full-screen clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLR_ALL;
      clr_pend_q <= 1'b1;
      clr_col_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= ASCII_SPACE;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      clr_col_q  <= clr_col_d;
      col_q      <= col_d;
      row_q      <= row_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
    end
  end

  assign char_ready = ready_q;
  assign buf_we     = we_q;
  assign buf_addr   = addr_q;
  assign buf_data   = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: directed scenarios plus a
// random byte stream, each byte checked against a screen-level model.
module tb_text_console_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int SCREEN = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              char_valid = 1'b0;
  logic [7:0]        char_data = 8'h00;
  logic              char_ready;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic [5:0]        scroll_row;
  logic [6:0]        cursor_col;
  logic [5:0]        cursor_row;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .scroll_row (scroll_row),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // observed writes, packed as addr*256 + data
  int obs_q[$];
  // capture buffer writes mid-cycle
  always @(negedge clk) begin
    if (buf_we) obs_q.push_back(int'(buf_addr) * 256 + int'(buf_data));
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- screen-level reference model ----------------
  int m_col, m_row, m_scroll;
  int exp_q[$];
  int exp_stall;

  function automatic int m_addr(input int row, input int col);
    return ((m_scroll + row) % ROWS) * COLS + col;
  endfunction

  task automatic model_home();
    m_col = 0; m_row = 0; m_scroll = 0;
  endtask

  // returns 1 when the row advance scrolled the screen
  task automatic model_newline(output bit scrolled);
    scrolled = 1'b0;
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      m_scroll = (m_scroll + 1) % ROWS;
      for (int c = 0; c < COLS; c++) exp_q.push_back(m_addr(m_row, c) * 256 + 32);
      scrolled = 1'b1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit sc;
    exp_q.delete();
    exp_stall = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(m_addr(m_row, m_col) * 256 + int'(b));
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_newline(sc);
        if (sc) exp_stall = COLS + 1;
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      model_newline(sc);
      if (sc) exp_stall = COLS;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back(m_addr(m_row, m_col) * 256 + 32);
      end
    end else if (b == 8'h0C) begin
      for (int a = 0; a < SCREEN; a++) exp_q.push_back(a * 256 + 32);
      model_home();
      exp_stall = SCREEN;
    end
  endtask

  // ---------------- drivers ----------------
  // offer one byte (called just after a negedge) until it is taken
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    char_valid = 1'b1;
    char_data  = b;
    while (!char_ready && n < 6000) begin
      @(negedge clk); #1; n++;
    end
    if (!char_ready) check_val("send_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  // send one byte and compare every effect against the model
  task automatic step(input logic [7:0] b, input string tag);
    int stall, bad, n;
    model_byte(b);
    obs_q.delete();
    send(b);
    #1;
    stall = 0;
    while (!char_ready && stall < 6000) begin
      @(negedge clk); #1; stall++;
    end
    check_val({tag, "_stall"}, stall, exp_stall);
    check_val({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    bad = 0;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] != exp_q[i]) bad++;
    if (bad != 0 && n > 0)
      $display("  %s first write addr*256+data observed %0d expected %0d", tag, obs_q[0], exp_q[0]);
    check_val({tag, "_wrdata"}, bad, 0);
    check_val({tag, "_col"}, int'(cursor_col), m_col);
    check_val({tag, "_row"}, int'(cursor_row), m_row);
    check_val({tag, "_scroll"}, int'(scroll_row), m_scroll);
  endtask

  task automatic step_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(s[i], tag);
  endtask

  task automatic step_rep(input logic [7:0] b, input int n, input string tag);
    for (int i = 0; i < n; i++) step(b, tag);
  endtask

  // hold reset two cycles, then verify the power-on clear
  task automatic reset_seq(input string tag);
    int k, bad;
    rst_n = 1'b0;
    char_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val({tag, "_rst_ready"}, int'(char_ready), 0);
    check_val({tag, "_rst_we"}, int'(buf_we), 0);
    check_val({tag, "_rst_addr"}, int'(buf_addr), 0);
    check_val({tag, "_rst_data"}, int'(buf_data), 32);
    check_val({tag, "_rst_scroll"}, int'(scroll_row), 0);
    check_val({tag, "_rst_cursor"}, int'(cursor_col) + int'(cursor_row), 0);
    obs_q.delete();
    rst_n = 1'b1;
    k = 0;
    while (!char_ready && k < 6000) begin
      @(negedge clk); #1; k++;
    end
    check_val({tag, "_ready_cycle"}, k, SCREEN + 1);
    check_val({tag, "_clr_count"}, obs_q.size(), SCREEN);
    bad = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] != i * 256 + 32) bad++;
    check_val({tag, "_clr_seq"}, bad, 0);
    check_val({tag, "_scroll0"}, int'(scroll_row), 0);
    check_val({tag, "_cursor0"}, int'(cursor_col) + int'(cursor_row), 0);
    model_home();
  endtask

  logic [7:0] rb;
  int         ff_left;
  int         r, k;

  initial begin
    @(negedge clk); #1;
    reset_seq("por");

    // basic text with CR/LF
    step_str("AB\r\nC", "abcrlf");
    check_val("abcrlf_pos", int'(cursor_row) * 100 + int'(cursor_col), 101);

    // 81 chars from home wrap onto row 1 with no stall
    step(8'h0C, "ff1");
    step_rep(8'h78, 81, "x81");
    check_val("x81_pos", int'(cursor_row) * 100 + int'(cursor_col), 101);

    // LF at bottom row scrolls and blanks physical row 0
    step(8'h0C, "ff2");
    step_rep(8'h0A, 59, "lf59");
    step(8'h0A, "scroll_lf");
    check_val("scroll_lf_scroll", int'(scroll_row), 1);
    step(8'h5A, "z_after");
    check_val("z_after_pos", int'(cursor_row) * 100 + int'(cursor_col), 5901);

    // backspace edges and ignored control byte
    step(8'h0C, "ff3");
    step_rep(8'h0A, 5, "lf5");
    step(8'h08, "bs_col0");
    step_str("aaa", "aaa");
    step(8'h08, "bs_col3");
    check_val("bs_col3_pos", int'(cursor_row) * 100 + int'(cursor_col), 502);
    step(8'h07, "bel");

    // printable in last column of bottom row: write, then line clear
    step(8'h0A, "lf");
    step_rep(8'h0A, 53, "lf53");
    step_rep(8'h71, 79, "q79");
    step(8'h21, "wrap_bottom");

    // random stream
    ff_left = 2;
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 299);
      if (r < 200)      rb = 8'($urandom_range(32, 126));
      else if (r < 240) rb = 8'h0A;
      else if (r < 255) rb = 8'h0D;
      else if (r < 275) rb = 8'h08;
      else if (r < 285) rb = 8'($urandom_range(128, 255));
      else if (r < 290) rb = 8'h07;
      else if (r < 299) rb = 8'h7F;
      else if (ff_left > 0) begin rb = 8'h0C; ff_left--; end
      else              rb = 8'h0A;
      step(rb, "rnd");
    end

    // reset in the middle of a form-feed clear
    send(8'h0C);
    #1;
    k = 0;
    while (!(buf_we && buf_addr == 13'd2000) && k < 6000) begin
      @(negedge clk); #1; k++;
    end
    check_val("ff_mid_addr", int'(buf_addr), 2000);
    reset_seq("midrst");
    step_str("ok", "post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
